// File: rtl/div_12by6_seq.sv
// div_12by6_seq: sequential restoring divider, DW-bit dividend / VW-bit
// divisor, one quotient bit per clock, start/ready/done handshake.
//
// Optional build macro: DIV_FAST_SMALL_EN
//   When defined, an accepted operation whose dividend is smaller than a
//   nonzero divisor bypasses the iteration and finishes in 2 cycles.
//   Results are identical either way; only latency changes.
//
// Ports:
//   i_clk          clock, rising edge
//   i_rst          synchronous active-high reset
//   i_start        request, sampled only while o_ready=1
//   i_dividend     dividend, captured on accept
//   i_divisor      divisor, captured on accept
//   o_ready        idle, can accept a start
//   o_done         one-cycle pulse, results valid
//   o_quotient     quotient, held until the next result
//   o_remainder    remainder, held until the next result
//   o_div_by_zero  set with done when the captured divisor was 0
//
// state  | meaning
// S_IDLE | waiting for start (ready unless the done pulse is showing)
// S_RUN  | shifting/subtracting, one quotient bit per edge
// S_FIN  | publish results; done pulses in the following cycle

module div_12by6_seq #(
    parameter int DW = 12,
    parameter int VW = 6,
    parameter int CW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_ready,
    output logic          o_done,
    output logic [DW-1:0] o_quotient,
    output logic [VW-1:0] o_remainder,
    output logic          o_div_by_zero
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [DW-1:0] r_q;
    logic [VW-1:0] r_d;
    logic [VW-1:0] r_r;
    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_rem;
    logic          r_dbz;

    logic          w_accept;
    logic          w_small;
    logic [VW:0]   w_t;
    logic          w_ge;
    logic [VW-1:0] w_diff;

    assign w_accept = o_ready && i_start;

`ifdef DIV_FAST_SMALL_EN
    assign w_small = (i_divisor != '0) && (i_dividend < DW'(i_divisor));
`else
    assign w_small = 1'b0;
`endif

    // The partial remainder is always < D, so it is kept VW bits wide; only
    // the trial value T needs the extra bit. When T >= D the difference is
    // < D as well, so a VW-bit subtraction is exact.
    assign w_t    = {r_r, r_q[DW-1]};
    assign w_ge   = (w_t >= {1'b0, r_d});
    assign w_diff = w_t[VW-1:0] - r_d;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ((i_divisor == '0) || w_small) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = S_FIN;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Done is registered, so it shows while the FSM is already back in IDLE;
    // that cycle must not accept a new start.
    always_comb begin
        o_ready       = (r_state == S_IDLE) && !r_done;
        o_done        = r_done;
        o_quotient    = r_quot;
        o_remainder   = r_rem;
        o_div_by_zero = r_dbz;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q    <= '0;
            r_d    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_d   <= i_divisor;
                        r_cnt <= CW'(DW);
                        if (w_small) begin
                            r_q <= '0;
                            r_r <= i_dividend[VW-1:0];
                        end else begin
                            r_q <= i_dividend;
                            r_r <= '0;
                        end
                    end
                end
                S_RUN: begin
                    r_q   <= {r_q[DW-2:0], w_ge};
                    r_r   <= w_ge ? w_diff : w_t[VW-1:0];
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIN: begin
                    r_done <= 1'b1;
                    if (r_d == '0) begin
                        r_quot <= '1;
                        r_rem  <= '0;
                        r_dbz  <= 1'b1;
                    end else begin
                        r_quot <= r_q;
                        r_rem  <= r_r;
                        r_dbz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_12by6_seq.sv
module tb_div_12by6_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] dividend;
    logic [5:0]  divisor;
    logic        ready;
    logic        done;
    logic [11:0] quotient;
    logic [5:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [11:0] q;
        logic [5:0]  r;
        logic        dbz;
    } exp_t;

    exp_t sb[$];

`ifdef DIV_FAST_SMALL_EN
    localparam int SMALL_LAT = 2;
`else
    localparam int SMALL_LAT = 14;
`endif

    div_12by6_seq dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_dividend    (dividend),
        .i_divisor     (divisor),
        .o_ready       (ready),
        .o_done        (done),
        .o_quotient    (quotient),
        .o_remainder   (remainder),
        .o_div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a start at the current negedge once ready is seen.
    task automatic issue(input logic [11:0] dvd, input logic [5:0] dvs, input bit push);
        exp_t e;
        int w = 0;
        while (ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("ready_before_start", {31'd0, ready}, 32'd1);
        start    = 1'b1;
        dividend = dvd;
        divisor  = dvs;
        if (push) begin
            if (dvs == 6'd0) begin
                e.q = 12'hFFF; e.r = 6'd0; e.dbz = 1'b1;
            end else begin
                e.q = 12'(int'(dvd) / int'(dvs));
                e.r = 6'(int'(dvd) % int'(dvs));
                e.dbz = 1'b0;
            end
            sb.push_back(e);
        end
    endtask

    // Count cycles from the start cycle until done, then score the result.
    task automatic finish_op(input int exp_lat, input string tag, input bit churn);
        int cyc = 0;
        exp_t e;
        do begin
            @(negedge clk);
            cyc++;
            if (churn) begin
                start    = 1'b1;
                dividend = 12'($urandom);
                divisor  = 6'($urandom);
            end else begin
                start = 1'b0;
            end
        end while (done !== 1'b1 && cyc < 40);
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_ready_in_done"}, {31'd0, ready}, 32'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_quotient"}, {20'd0, quotient}, {20'd0, e.q});
            chk({tag, "_remainder"}, {26'd0, remainder}, {26'd0, e.r});
            chk({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, e.dbz});
        end else begin
            chk({tag, "_scoreboard_entry"}, 32'd0, 32'd1);
        end
    endtask

    task automatic op(input logic [11:0] dvd, input logic [5:0] dvs, input int lat, input string tag);
        issue(dvd, dvs, 1'b1);
        finish_op(lat, tag, 1'b0);
        @(negedge clk);
        chk({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
        chk({tag, "_done_after"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_quotient", {20'd0, quotient}, 32'd0);
        chk("reset_remainder", {26'd0, remainder}, 32'd0);
        chk("reset_dbz", {31'd0, div_by_zero}, 32'd0);

        op(12'd100, 6'd7, 14, "d100_7");
        op(12'd4095, 6'd63, 14, "d4095_63");
        op(12'd4095, 6'd1, 14, "d4095_1");
        op(12'd3969, 6'd63, 14, "d3969_63");
        op(12'd5, 6'd0, 2, "d5_0");
        op(12'd9, 6'd3, 14, "d9_3");
        op(12'd10, 6'd20, SMALL_LAT, "d10_20");

        // Abort mid-iteration with reset.
        issue(12'd200, 6'd9, 1'b0);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_done_before", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_quotient", {20'd0, quotient}, 32'd0);
        chk("abort_remainder", {26'd0, remainder}, 32'd0);
        chk("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("abort_no_done_after", {31'd0, done}, 32'd0);
        end
        op(12'd200, 6'd9, 14, "d200_9");

        // Start held high with changing operands while busy.
        issue(12'd77, 6'd5, 1'b1);
        finish_op(14, "churn", 1'b1);
        @(negedge clk);
        chk("churn_ready_after", {31'd0, ready}, 32'd1);
        issue(12'd1000, 6'd10, 1'b1);
        finish_op(14, "d1000_10", 1'b0);
        @(negedge clk);
        chk("d1000_10_ready_after", {31'd0, ready}, 32'd1);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
